// File: rtl/morse_entry_ctrl.sv
// morse_entry_ctrl
//   Sequencer in front of the character shift register. It edge-detects the
//   debounced dot/dash/commit/backspace levels and builds a symbol (element
//   bits plus length). It pulses flag to append the symbol, or backspace to
//   delete the last displayed character. It also tracks the display fill
//   level, auto-commits after an idle timeout and flags rejected input on err.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   1 = accept input and run the timeout, 0 = freeze
//   dot_btn    in   debounced level, 1 = pressed
//   dash_btn   in   debounced level, 1 = pressed
//   commit_btn in   debounced level, 1 = pressed
//   bksp_btn   in   debounced level, 1 = pressed
//   key_val    out  [3:0] element bits, 1 = dash, first element in bit 0
//   key_len    out  [2:0] element count 0..MAX_ELEM
//   flag       out  one-cycle pulse: append {key_val, key_len}
//   backspace  out  one-cycle pulse: delete the last displayed char
//   char_cnt   out  [3:0] characters on display, 0..MAX_CHARS
//   busy       out  1 while state != IDLE
//   err        out  one-cycle pulse on a rejected event
module morse_entry_ctrl #(
   parameter int TIMEOUT   = 50_000_000,
   parameter int MAX_CHARS = 8,
   parameter int MAX_ELEM  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       dot_btn,
   input  logic       dash_btn,
   input  logic       commit_btn,
   input  logic       bksp_btn,
   output logic [3:0] key_val,
   output logic [2:0] key_len,
   output logic       flag,
   output logic       backspace,
   output logic [3:0] char_cnt,
   output logic       busy,
   output logic       err
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUILD, COMMIT, BKSP} state_t;

   state_t          state_reg, state_next;
   logic [3:0]      key_val_reg, key_val_next;
   logic [2:0]      key_len_reg, key_len_next;
   logic [3:0]      char_cnt_reg, char_cnt_next;
   logic [CW-1:0]   idle_reg, idle_next;
   logic            flag_reg, flag_next;
   logic            backspace_reg, backspace_next;
   logic            err_reg, err_next;
   logic            busy_reg;

   // Button vector order: {bksp, commit, dash, dot}
   logic [3:0] btn_now;
   logic [3:0] btn_q_reg;
   logic [3:0] rise;

   assign btn_now = {bksp_btn, commit_btn, dash_btn, dot_btn};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_edge
         assign rise[gi] = btn_now[gi] & ~btn_q_reg[gi];
      end
   endgenerate

   // One event per cycle, priority bksp > commit > dash > dot.
   logic ev_bksp, ev_commit, ev_dash, ev_dot, ev_elem;
   assign ev_bksp   = en & rise[3];
   assign ev_commit = en & rise[2] & ~rise[3];
   assign ev_dash   = en & rise[1] & ~rise[3] & ~rise[2];
   assign ev_dot    = en & rise[0] & ~rise[3] & ~rise[2] & ~rise[1];
   assign ev_elem   = ev_dash | ev_dot;

   // Slot for the next element, and slot of the last element (wraps to 3 at len 4).
   logic [1:0] set_idx, top_idx;
   assign set_idx = key_len_reg[1:0];
   assign top_idx = key_len_reg[1:0] - 2'd1;

   logic [3:0] char_inc;
   assign char_inc = (char_cnt_reg == 4'(MAX_CHARS)) ? char_cnt_reg : char_cnt_reg + 4'd1;

   always_comb begin
      state_next     = state_reg;
      key_val_next   = key_val_reg;
      key_len_next   = key_len_reg;
      char_cnt_next  = char_cnt_reg;
      idle_next      = idle_reg;
      flag_next      = 1'b0;
      backspace_next = 1'b0;
      err_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (ev_bksp) begin
               if (char_cnt_reg != 4'd0) begin
                  state_next     = BKSP;
                  backspace_next = 1'b1;
                  char_cnt_next  = char_cnt_reg - 4'd1;
               end else begin
                  err_next = 1'b1;
               end
            end else if (ev_commit) begin
               err_next = 1'b1;           // nothing to commit
            end else if (ev_elem) begin
               state_next   = BUILD;
               key_val_next = {3'b000, ev_dash};
               key_len_next = 3'd1;
               idle_next    = '0;
            end
         end

         BUILD: begin
            if (ev_bksp) begin
               key_val_next[top_idx] = 1'b0;
               key_len_next          = key_len_reg - 3'd1;
               idle_next             = '0;
               if (key_len_reg == 3'd1)
                  state_next = IDLE;
            end else if (ev_commit) begin
               state_next    = COMMIT;
               flag_next     = 1'b1;
               char_cnt_next = char_inc;
            end else if (ev_elem) begin
               if (key_len_reg < 3'(MAX_ELEM)) begin
                  key_val_next[set_idx] = ev_dash;
                  key_len_next          = key_len_reg + 3'd1;
                  idle_next             = '0;
               end else begin
                  // Rejected: counter held so a timeout due this cycle fires
                  // next cycle instead of colliding with err.
                  err_next = 1'b1;
               end
            end else if (en) begin
               if (idle_reg == CW'(TIMEOUT - 1)) begin
                  state_next    = COMMIT;
                  flag_next     = 1'b1;
                  char_cnt_next = char_inc;
               end else begin
                  idle_next = idle_reg + 1'b1;
               end
            end
         end

         // The pulse was issued on entry; these one-cycle states always
         // retire so a freeze can never stretch flag or backspace.
         COMMIT: begin
            state_next   = IDLE;
            key_val_next = 4'd0;
            key_len_next = 3'd0;
         end

         BKSP: begin
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // History follows the level even in reset, so a button held through
      // reset is not seen as a new press afterwards.
      btn_q_reg <= btn_now;
      if (rst) begin
         state_reg     <= IDLE;
         key_val_reg   <= 4'd0;
         key_len_reg   <= 3'd0;
         char_cnt_reg  <= 4'd0;
         idle_reg      <= '0;
         flag_reg      <= 1'b0;
         backspace_reg <= 1'b0;
         err_reg       <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         key_val_reg   <= key_val_next;
         key_len_reg   <= key_len_next;
         char_cnt_reg  <= char_cnt_next;
         idle_reg      <= idle_next;
         flag_reg      <= flag_next;
         backspace_reg <= backspace_next;
         err_reg       <= err_next;
         busy_reg      <= (state_next != IDLE);
      end
   end

   assign key_val   = key_val_reg;
   assign key_len   = key_len_reg;
   assign flag      = flag_reg;
   assign backspace = backspace_reg;
   assign char_cnt  = char_cnt_reg;
   assign busy      = busy_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_morse_entry_ctrl.sv
// tb_morse_entry_ctrl
//   Directed bench for morse_entry_ctrl (TIMEOUT=16, MAX_CHARS=8, MAX_ELEM=4).
//   Each press drives buttons for one clock edge after a one-edge release
//   gap; outputs are sampled 1 ns after the edge that takes the event.
module tb_morse_entry_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic       dot_btn = 1'b0, dash_btn = 1'b0, commit_btn = 1'b0, bksp_btn = 1'b0;
   logic [3:0] key_val;
   logic [2:0] key_len;
   logic       flag, backspace, busy, err;
   logic [3:0] char_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [3:0] B_DOT = 4'h1, B_DASH = 4'h2, B_COMMIT = 4'h4, B_BKSP = 4'h8;

   morse_entry_ctrl #(.TIMEOUT(16), .MAX_CHARS(8), .MAX_ELEM(4)) dut (
      .clk(clk), .rst(rst), .en(en),
      .dot_btn(dot_btn), .dash_btn(dash_btn), .commit_btn(commit_btn), .bksp_btn(bksp_btn),
      .key_val(key_val), .key_len(key_len), .flag(flag), .backspace(backspace),
      .char_cnt(char_cnt), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input logic [3:0] b);
      {bksp_btn, commit_btn, dash_btn, dot_btn} = b;
   endtask

   // Release gap edge, then one edge with the buttons down.
   task automatic press(input logic [3:0] b);
      step();
      set_btn(b);
      step();
      set_btn(4'h0);
   endtask

   initial begin
      // ---- reset ----
      repeat (3) step();
      check("rst_key_val", key_val, 0);
      check("rst_key_len", key_len, 0);
      check("rst_pulses", {flag, backspace, err, busy}, 0);
      check("rst_char_cnt", char_cnt, 0);
      rst = 1'b0;

      // ---- 1: dot, dash, dash, commit ----
      press(B_DOT);
      check("t1_len1", key_len, 1);
      check("t1_busy", busy, 1);
      press(B_DASH);
      check("t1_val2", key_val, 4'b0010);
      press(B_DASH);
      check("t1_len3", key_len, 3);
      press(B_COMMIT);
      check("t1_flag", flag, 1);
      check("t1_val", key_val, 4'b0110);
      check("t1_len", key_len, 3);
      check("t1_cnt", char_cnt, 1);
      step();
      check("t1_flag_off", flag, 0);
      check("t1_cleared", {key_val, 1'b0, key_len}, 0);
      check("t1_idle", busy, 0);

      // ---- 2: dash x5, commit ----
      repeat (4) press(B_DASH);
      check("t2_len4", key_len, 4);
      check("t2_noerr", err, 0);
      press(B_DASH);
      check("t2_err", err, 1);
      check("t2_len_held", key_len, 4);
      step();
      check("t2_err_off", err, 0);
      press(B_COMMIT);
      check("t2_flag", flag, 1);
      check("t2_val", key_val, 4'b1111);
      check("t2_len", key_len, 4);
      check("t2_cnt", char_cnt, 2);

      // ---- 3: timeout auto-commit ----
      press(B_DOT);
      repeat (15) step();
      check("t3_no_flag_early", flag, 0);
      check("t3_still_build", busy, 1);
      step();
      check("t3_flag", flag, 1);
      check("t3_val", key_val, 0);
      check("t3_len", key_len, 1);
      check("t3_cnt", char_cnt, 3);
      step();
      check("t3_flag_off", flag, 0);

      // ---- 4: backspace paths and saturation ----
      press(B_BKSP);
      check("t4_bksp", backspace, 1);
      check("t4_bksp_cnt", char_cnt, 2);
      check("t4_bksp_noflag", flag, 0);
      step();
      check("t4_bksp_off", backspace, 0);
      press(B_BKSP);
      press(B_BKSP);
      check("t4_cnt0", char_cnt, 0);
      press(B_BKSP);
      check("t4_empty_err", err, 1);
      check("t4_empty_nobksp", backspace, 0);
      press(B_COMMIT);
      check("t4_empty_commit_err", {err, flag}, 2'b10);
      press(B_DOT);
      press(B_DASH);
      check("t4_len2", key_len, 2);
      press(B_BKSP);
      check("t4_len1", key_len, 1);
      check("t4_val1", key_val, 0);
      check("t4_no_bksp_pulse", backspace, 0);
      press(B_BKSP);
      check("t4_len0", key_len, 0);
      check("t4_back_idle", busy, 0);
      for (int i = 1; i <= 9; i++) begin
         press(B_DOT);
         press(B_COMMIT);
         if (i == 8) check("t4_cnt8", char_cnt, 8);
      end
      check("t4_sat_flag", flag, 1);
      check("t4_sat_cnt", char_cnt, 8);

      // ---- 5: simultaneous bksp+commit+dot ----
      repeat (5) press(B_BKSP);
      check("t5_cnt3", char_cnt, 3);
      press(B_BKSP | B_COMMIT | B_DOT);
      check("t5_pulses", {backspace, flag, err}, 3'b100);
      check("t5_cnt2", char_cnt, 2);
      step();
      check("t5_dot_dropped", {busy, key_len}, 0);

      // ---- freeze holds the timeout ----
      press(B_DOT);
      en = 1'b0;
      repeat (20) step();
      check("frz_no_flag", flag, 0);
      check("frz_held", {busy, key_len}, {1'b1, 3'd1});
      en = 1'b1;
      repeat (15) step();
      check("frz_no_flag_early", flag, 0);
      step();
      check("frz_flag", flag, 1);
      check("frz_cnt", char_cnt, 3);

      // ---- 6: rst on the commit edge, en=0 while dot held ----
      press(B_DOT);
      step();
      set_btn(B_COMMIT);
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_btn(4'h0);
      check("t6_rst_outs", {flag, backspace, err, busy, key_len, char_cnt}, 0);
      step();
      check("t6_no_late_flag", flag, 0);
      en = 1'b0;
      set_btn(B_DOT);
      repeat (3) step();
      check("t6_frozen", {busy, key_len}, 0);
      en = 1'b1;
      repeat (3) step();
      check("t6_no_retrigger", {busy, key_len, err}, 0);
      set_btn(4'h0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
